// File: rtl/ldd_stream_pkg.sv
// Shared helpers for the lowest-set-bit stream decoder.
// Latency: n/a (constants and combinational functions only).
// Backpressure: n/a.
//
// Widths derived from the module parameters are computed with idx_w_f and
// sel_n_f so that ports, sub-modules and the result struct agree.
// lo_index_f supports words up to LDD_MAX_W bits.
package ldd_stream_pkg;

  localparam int LDD_MAX_W = 64;

  // Width of an index that must also be able to encode "no bit set" (= w).
  function automatic int idx_w_f(input int w);
    return $clog2(w + 1);
  endfunction

  // Number of one-hot select outputs for {mode, sel_w low data bits}.
  function automatic int sel_n_f(input int sel_w);
    return 2 ** (sel_w + 1);
  endfunction

  // Index of the lowest set bit among the low w bits of data; w when none set.
  // Scanning downward lets the lowest set bit be the last assignment.
  function automatic int lo_index_f(input logic [LDD_MAX_W-1:0] data, input int w);
    int idx;
    idx = w;
    for (int i = LDD_MAX_W - 1; i >= 0; i--) begin
      if ((i < w) && data[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ldd_lo_detect.sv
// Combinational lowest-set-bit detector: one-hot position, binary index, zero flag.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller owns all handshaking.
//
// Ports:
//   data   - W-bit word to scan (W <= LDD_MAX_W)
//   onehot - bit k set iff data[k]=1 and data[k-1:0]=0; zero for a zero word
//   index  - k as above, W for a zero word
//   zero   - data is all zeros
module ldd_lo_detect
  import ldd_stream_pkg::*;
#(
  parameter int W     = 8,
  parameter int IDX_W = idx_w_f(W)
) (
  input  logic [W-1:0]     data,
  output logic [W-1:0]     onehot,
  output logic [IDX_W-1:0] index,
  output logic             zero
);

  // Two's-complement trick: data & -data isolates the lowest set bit.
  assign onehot = data & (~data + W'(1));
  assign index  = IDX_W'(lo_index_f(LDD_MAX_W'(data), W));
  assign zero   = ~|data;

endmodule

// File: rtl/ldd_stream_decoder.sv
// Pipelined decoder: lowest set bit, {mode,sel} one-hot and saturating zero-word count.
// Latency: 2 cycles from input transfer to out_valid; 1 beat/cycle throughput.
// Backpressure: out_ready stalls S2, in_ready = ~s1_valid | s2_take (combinational).
//
// Ports:
//   clk, rst_n           - clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    - input handshake; in_data (W bits) and in_mode sampled on transfer
//   out_valid/out_ready  - output handshake; out_* held stable while stalled
//   out_lo_onehot/index  - lowest set bit (one-hot / binary, index = W for zero word)
//   out_zero             - word was all zeros
//   out_sel_onehot       - one-hot of {in_mode, in_data[SEL_W-1:0]}
//   out_par              - XOR of the word when LDD_STREAM_PARITY_EN is defined, else 0
//   zero_cnt             - saturating count of zero words loaded into S2; reset-only clear
module ldd_stream_decoder
  import ldd_stream_pkg::*;
#(
  parameter int W     = 8,
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_data,
  input  logic                    in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_lo_onehot,
  output logic [$clog2(W+1)-1:0]  out_lo_index,
  output logic                    out_zero,
  output logic [2**(SEL_W+1)-1:0] out_sel_onehot,
  output logic                    out_par,
  output logic [CNT_W-1:0]        zero_cnt
);

  localparam int IDX_W = idx_w_f(W);
  localparam int SEL_N = sel_n_f(SEL_W);

  typedef struct packed {
    logic [W-1:0]     onehot;
    logic [IDX_W-1:0] index;
    logic             zero;
    logic [SEL_N-1:0] sel;
  } res_t;

  logic             s1_valid;
  logic [W-1:0]     s1_data;
  logic             s1_mode;
  logic             s2_take;

  logic [W-1:0]     lo_onehot;
  logic [IDX_W-1:0] lo_index;
  logic             lo_zero;
  logic [SEL_W:0]   sel_idx;
  res_t             dec;
  res_t             s2_q;

  // S2 can accept whenever it is empty or its beat leaves this cycle,
  // so a full pipeline still streams one beat per cycle.
  assign s2_take  = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_take;

  // ---------------- Stage 1: capture the beat ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      // Data only moves on a real transfer; idle cycles leave it untouched.
      if (in_valid) begin
        s1_data <= in_data;
        s1_mode <= in_mode;
      end
    end
  end

  // ---------------- Decode between S1 and S2 ----------------
  ldd_lo_detect #(
    .W     (W),
    .IDX_W (IDX_W)
  ) u_lo_detect (
    .data   (s1_data),
    .onehot (lo_onehot),
    .index  (lo_index),
    .zero   (lo_zero)
  );

  assign sel_idx = {s1_mode, s1_data[SEL_W-1:0]};

  always_comb begin
    dec        = '0;
    dec.onehot = lo_onehot;
    dec.index  = lo_index;
    dec.zero   = lo_zero;
    dec.sel    = SEL_N'(1) << sel_idx;
  end

  // ---------------- Stage 2: registered results ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s2_q      <= '0;
      zero_cnt  <= '0;
    end else if (s2_take) begin
      out_valid <= s1_valid;
      // A bubble leaves the previous results in place.
      if (s1_valid) begin
        s2_q <= dec;
        if (dec.zero && (zero_cnt != {CNT_W{1'b1}})) begin
          zero_cnt <= zero_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign out_lo_onehot  = s2_q.onehot;
  assign out_lo_index   = s2_q.index;
  assign out_zero       = s2_q.zero;
  assign out_sel_onehot = s2_q.sel;

`ifdef LDD_STREAM_PARITY_EN
  logic par_q;

  // Same load/hold rule as the rest of S2 so parity stays aligned with its beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (s2_take && s1_valid) begin
      par_q <= ^s1_data;
    end
  end

  assign out_par = par_q;
`else
  assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_ldd_stream_decoder.sv
// Scoreboard bench for ldd_stream_decoder: random and directed beats checked against
// a behavioural model; a second instance with CNT_W=2 exercises counter saturation.
module tb_ldd_stream_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Main DUT (W=8, SEL_W=3, CNT_W=16)
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_lo_onehot;
  logic [3:0]  out_lo_index;
  logic        out_zero;
  logic [15:0] out_sel_onehot;
  logic        out_par;
  logic [15:0] zero_cnt;

  // Saturation DUT (CNT_W=2)
  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [7:0]  in_data2 = 8'h00;
  logic        in_mode2 = 1'b0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [7:0]  out_lo_onehot2;
  logic [3:0]  out_lo_index2;
  logic        out_zero2;
  logic [15:0] out_sel_onehot2;
  logic        out_par2;
  logic [1:0]  zero_cnt2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  oh;
    logic [3:0]  idx;
    logic        z;
    logic [15:0] sel;
    logic        par;
    int          zc;
  } exp_t;

  exp_t sb[$];
  int   cum_zero = 0;
  bit   rand_ready = 0;

  ldd_stream_decoder #(.W(8), .SEL_W(3), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_mode        (in_mode),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_lo_onehot  (out_lo_onehot),
    .out_lo_index   (out_lo_index),
    .out_zero       (out_zero),
    .out_sel_onehot (out_sel_onehot),
    .out_par        (out_par),
    .zero_cnt       (zero_cnt)
  );

  ldd_stream_decoder #(.W(8), .SEL_W(3), .CNT_W(2)) dut2 (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid2),
    .in_ready       (in_ready2),
    .in_data        (in_data2),
    .in_mode        (in_mode2),
    .out_valid      (out_valid2),
    .out_ready      (out_ready2),
    .out_lo_onehot  (out_lo_onehot2),
    .out_lo_index   (out_lo_index2),
    .out_zero       (out_zero2),
    .out_sel_onehot (out_sel_onehot2),
    .out_par        (out_par2),
    .zero_cnt       (zero_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: lowest set bit found by a plain scan, select by arithmetic.
  function automatic exp_t model(input logic [7:0] d, input logic m, input int zc);
    exp_t e;
    int k = 8;
    int s;
    logic [15:0] one16 = 16'h0001;
    for (int i = 0; i < 8; i++) if (k == 8 && d[i]) k = i;
    e.idx = 4'(k);
    e.oh  = (k == 8) ? 8'h00 : 8'(32'd1 << k);
    e.z   = (d == 8'h00);
    s     = (m ? 8 : 0) + int'(d % 8);
    e.sel = one16 << s;
`ifdef LDD_STREAM_PARITY_EN
    e.par = ($countones(d) % 2) == 1;
`else
    e.par = 1'b0;
`endif
    e.zc  = zc;
    return e;
  endfunction

  // Input side: every accepted beat pushes its expected result.
  initial forever begin
    @(negedge clk);
    if (rst_n && in_valid && in_ready) begin
      if (in_data == 8'h00 && cum_zero < 65535) cum_zero++;
      sb.push_back(model(in_data, in_mode, cum_zero));
    end
  end

  // Output side: any presented beat (held or not) must match the queue head.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = sb[0];
        check("lo_onehot", 32'(out_lo_onehot), 32'(e.oh));
        check("lo_index",  32'(out_lo_index),  32'(e.idx));
        check("zero",      32'(out_zero),      32'(e.z));
        check("sel_onehot", 32'(out_sel_onehot), 32'(e.sel));
        check("par",       32'(out_par),       32'(e.par));
        check("zero_cnt",  32'(zero_cnt),      32'(e.zc));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Random downstream backpressure when enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic send(input logic [7:0] d, input logic m);
    int  n = 0;
    logic got = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("send_accepted", 32'(got), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    rand_ready = 0;
    out_ready  = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int stale;
    // Reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_zero_cnt",  32'(zero_cnt),  32'd0);
    check("rst_onehot",    32'(out_lo_onehot), 32'd0);
    check("rst_sel",       32'(out_sel_onehot), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed patterns with no backpressure
    send(8'h80, 1'b0);
    send(8'h06, 1'b1);
    send(8'h07, 1'b1);
    send(8'h00, 1'b0);
    drain();

    // Backpressure: three beats, downstream stalled
    out_ready = 1'b0;
    send(8'h10, 1'b0);
    send(8'h00, 1'b1);
    check("in_ready_stalled", 32'(in_ready), 32'd0);
    fork
      send(8'h0C, 1'b1);
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random backpressure and idle gaps
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        in_data = 8'($urandom);
        in_mode = 1'($urandom);
        @(posedge clk);
        #1;
      end
      send(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), 1'($urandom));
    end
    drain();

    // Counter saturation on the CNT_W=2 instance
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      in_valid2 = 1'b1;
      in_data2  = 8'h00;
      in_mode2  = 1'($urandom);
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("sat_zero_cnt", 32'(zero_cnt2), (i < 3) ? 32'(i) : 32'd3);
    end

    // Reset with two beats in flight
    @(posedge clk);
    #1;
    send(8'h00, 1'b0);
    send(8'h11, 1'b1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    cum_zero = 0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_zero_cnt",  32'(zero_cnt),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("post_rst_no_stale", 32'(stale), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
